// File: rtl/cpx_src_arb_if.sv
// CPX return-path bundle between the requesters and the source arbiter.
// The master side is the requester/core environment; the slave side is the arbiter.
interface cpx_src_arb_if #(
    parameter int NSRC = 4,
    parameter int DW   = 145
);
    logic [NSRC-1:0]    src_req;
    logic [NSRC-1:0]    src_atom;
    logic [NSRC*DW-1:0] src_data;
    logic               cpx_stall;
    logic [NSRC-1:0]    src_grant;
    logic [DW-1:0]      cpx_spc_data_cx2;
    logic               cpx_spc_data_rdy_cx2;
    logic               arb_proto_err;

    modport master (
        output src_req, src_atom, src_data, cpx_stall,
        input  src_grant, cpx_spc_data_cx2, cpx_spc_data_rdy_cx2, arb_proto_err
    );

    modport slave (
        input  src_req, src_atom, src_data, cpx_stall,
        output src_grant, cpx_spc_data_cx2, cpx_spc_data_rdy_cx2, arb_proto_err
    );
endinterface

// File: rtl/cpx_src_arb.sv
// Round-robin CPX source arbiter: one registered packet per cycle into the core,
// atomic pairs kept back-to-back, stall blocks only new arbitration.
module cpx_src_arb #(
    parameter int NSRC = 4,
    parameter int DW   = 145
) (
    input  logic          rclk,
    input  logic          arst_l,
    cpx_src_arb_if.slave  bus
);
    localparam int             PW   = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [PW-1:0]  LAST = PW'(NSRC - 1);
    localparam logic [PW:0]    NS   = (PW + 1)'(NSRC);

    logic [PW-1:0]   r_ptr;
    logic            r_lock;
    logic [PW-1:0]   r_lock_id;
    logic [DW-1:0]   r_data;
    logic            r_rdy;
    logic            r_err;

    logic [NSRC-1:0] w_grant;
    logic [PW-1:0]   w_gid;
    logic            w_hit;
    logic            w_err;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_idx;

    // Scan from the farthest candidate down to ptr so the nearest requester
    // overwrites the others and wins; grant is forced off while in reset.
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_hit   = 1'b0;
        w_err   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        if (arst_l) begin
            if (r_lock) begin
                if (bus.src_req[r_lock_id]) begin
                    w_hit = 1'b1;
                    w_gid = r_lock_id;
                end else begin
                    w_err = 1'b1;
                end
            end else if (!bus.cpx_stall) begin
                for (int k = NSRC - 1; k >= 0; k--) begin
                    w_sum = {1'b0, r_ptr} + (PW + 1)'(k);
                    if (w_sum >= NS) w_sum = w_sum - NS;
                    w_idx = w_sum[PW-1:0];
                    if (bus.src_req[w_idx]) begin
                        w_hit = 1'b1;
                        w_gid = w_idx;
                    end
                end
            end
            if (w_hit) w_grant[w_gid] = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_ptr     <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rdy <= w_hit;
            r_err <= w_err;
            if (w_hit) r_data <= bus.src_data[int'(w_gid)*DW +: DW];
            // The second beat of a pair always releases the lock and never re-arms it.
            if (r_lock) begin
                r_lock <= 1'b0;
            end else if (w_hit) begin
                r_ptr <= (w_gid == LAST) ? '0 : w_gid + 1'b1;
                if (bus.src_atom[w_gid]) begin
                    r_lock    <= 1'b1;
                    r_lock_id <= w_gid;
                end
            end
        end
    end

    assign bus.src_grant            = w_grant;
    assign bus.cpx_spc_data_cx2     = r_data;
    assign bus.cpx_spc_data_rdy_cx2 = r_rdy;
    assign bus.arb_proto_err        = r_err;
endmodule

// File: tb/tb_cpx_src_arb.sv
// Scoreboard bench for cpx_src_arb: directed scenarios, then random traffic,
// checked against a distance-based round-robin reference model.
module tb_cpx_src_arb;
    localparam int N  = 4;
    localparam int DW = 145;

    typedef struct {
        logic          rdy;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic rclk   = 1'b0;
    logic arst_l = 1'b0;
    always #5 rclk = ~rclk;

    cpx_src_arb_if #(.NSRC(N), .DW(DW)) bus ();
    cpx_src_arb #(.NSRC(N), .DW(DW)) dut (.rclk(rclk), .arst_l(arst_l), .bus(bus.slave));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sbq[$];
    bit   in_rst  = 1'b1;

    // reference model state
    int            m_ptr  = 0;
    int            m_lid  = 0;
    int            m_g    = -1;
    bit            m_lock = 1'b0;
    logic [DW-1:0] m_last = '0;

    logic [DW-1:0] d [N];
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  atom  = '0;
    logic          stall = 1'b0;

    function automatic logic [DW-1:0] rnd_pkt();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive();
        bus.src_req   = req;
        bus.src_atom  = atom;
        bus.cpx_stall = stall;
        for (int i = 0; i < N; i++) bus.src_data[i*DW +: DW] = d[i];
    endtask

    // One arbitration cycle: apply inputs, predict the grant from the rules,
    // compare the combinational grant and queue the registered outcome.
    task automatic step(input string nm);
        exp_t         e;
        int           best;
        logic [N-1:0] eg;
        @(posedge rclk); #2;
        drive();
        #1;
        m_g   = -1;
        e.err = 1'b0;
        if (m_lock) begin
            if (req[m_lid]) m_g = m_lid;
            else            e.err = 1'b1;
            m_lock = 1'b0;
        end else if (!stall) begin
            best = N;
            for (int i = 0; i < N; i++)
                if (req[i] && ((i - m_ptr + N) % N) < best) begin
                    best = (i - m_ptr + N) % N;
                    m_g  = i;
                end
            if (m_g >= 0) begin
                m_ptr = (m_g + 1) % N;
                if (atom[m_g]) begin
                    m_lock = 1'b1;
                    m_lid  = m_g;
                end
            end
        end
        eg = (m_g >= 0) ? (N'(1) << m_g) : '0;
        chk({nm, ".grant"}, DW'(bus.src_grant), DW'(eg));
        if (m_g >= 0) m_last = d[m_g];
        e.rdy  = (m_g >= 0);
        e.data = m_last;
        sbq.push_back(e);
    endtask

    task automatic go(input string nm, input logic [N-1:0] r, input logic [N-1:0] a, input logic s);
        req   = r;
        atom  = a;
        stall = s;
        for (int i = 0; i < N; i++) d[i] = rnd_pkt();
        step(nm);
    endtask

    task automatic do_reset(input string nm);
        @(posedge rclk); #2;
        arst_l = 1'b0;
        in_rst = 1'b1;
        sbq.delete();
        #1;
        chk({nm, ".grant"}, DW'(bus.src_grant), '0);
        chk({nm, ".data"},  bus.cpx_spc_data_cx2, '0);
        chk({nm, ".rdy"},   DW'(bus.cpx_spc_data_rdy_cx2), '0);
        chk({nm, ".err"},   DW'(bus.arb_proto_err), '0);
        m_ptr  = 0;
        m_lock = 1'b0;
        m_lid  = 0;
        m_last = '0;
        req    = '0;
        atom   = '0;
        stall  = 1'b0;
        drive();
        @(posedge rclk); #2;
        arst_l = 1'b1;
        in_rst = 1'b0;
    endtask

    // Monitor: every cycle the registered outputs reflect the previous step.
    initial begin
        forever begin
            exp_t e;
            @(posedge rclk); #1;
            if (!in_rst) begin
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("mon.rdy",  DW'(bus.cpx_spc_data_rdy_cx2), DW'(e.rdy));
                    chk("mon.err",  DW'(bus.arb_proto_err), DW'(e.err));
                    chk("mon.data", bus.cpx_spc_data_cx2, e.data);
                end else begin
                    chk("mon.idle_rdy", DW'(bus.cpx_spc_data_rdy_cx2), '0);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) d[i] = '0;
        drive();
        do_reset("rst0");

        // single request, then check the registered packet one cycle later
        req = 4'b0001; atom = '0; stall = 1'b0;
        for (int i = 0; i < N; i++) d[i] = rnd_pkt();
        d[0] = DW'(12'h1AB);
        step("t1a");
        chk("t1a.g", DW'(bus.src_grant), DW'(4'b0001));
        go("t1b", 4'b0000, '0, 1'b0);
        chk("t1b.rdy",  DW'(bus.cpx_spc_data_rdy_cx2), DW'(1'b1));
        chk("t1b.data", bus.cpx_spc_data_cx2, DW'(12'h1AB));

        // all requesting from ptr=0
        go("t2p", 4'b1000, '0, 1'b0);
        chk("t2p.g", DW'(bus.src_grant), DW'(4'b1000));
        go("t2a", 4'b1111, '0, 1'b0); chk("t2a.g", DW'(bus.src_grant), DW'(4'b0001));
        go("t2b", 4'b1111, '0, 1'b0); chk("t2b.g", DW'(bus.src_grant), DW'(4'b0010));
        go("t2c", 4'b1111, '0, 1'b0); chk("t2c.g", DW'(bus.src_grant), DW'(4'b0100));
        go("t2d", 4'b1111, '0, 1'b0); chk("t2d.g", DW'(bus.src_grant), DW'(4'b1000));

        // atomic pair from source 2 with 0 and 3 waiting
        go("t3p", 4'b0010, '0, 1'b0);
        go("t3a", 4'b1101, 4'b0100, 1'b0); chk("t3a.g", DW'(bus.src_grant), DW'(4'b0100));
        go("t3b", 4'b1101, 4'b0100, 1'b0); chk("t3b.g", DW'(bus.src_grant), DW'(4'b0100));
        go("t3c", 4'b1001, 4'b0000, 1'b0); chk("t3c.g", DW'(bus.src_grant), DW'(4'b1000));
        go("t3d", 4'b0001, 4'b0000, 1'b0); chk("t3d.g", DW'(bus.src_grant), DW'(4'b0001));

        // stall rises on the second beat of a pair from source 1
        go("t4a", 4'b0010, 4'b0010, 1'b0); chk("t4a.g", DW'(bus.src_grant), DW'(4'b0010));
        go("t4b", 4'b0011, 4'b0000, 1'b1); chk("t4b.g", DW'(bus.src_grant), DW'(4'b0010));
        go("t4c", 4'b0001, 4'b0000, 1'b1); chk("t4c.g", DW'(bus.src_grant), '0);
        go("t4d", 4'b0001, 4'b0000, 1'b1); chk("t4d.g", DW'(bus.src_grant), '0);
        go("t4e", 4'b0001, 4'b0000, 1'b0); chk("t4e.g", DW'(bus.src_grant), DW'(4'b0001));

        // second beat missing -> one-cycle protocol error, lock released
        go("t5a", 4'b0001, 4'b0001, 1'b0); chk("t5a.g", DW'(bus.src_grant), DW'(4'b0001));
        go("t5b", 4'b0000, 4'b0000, 1'b0); chk("t5b.g", DW'(bus.src_grant), '0);
        go("t5c", 4'b0000, 4'b0000, 1'b0); chk("t5c.err", DW'(bus.arb_proto_err), DW'(1'b1));
        go("t5d", 4'b0100, 4'b0000, 1'b0); chk("t5d.err", DW'(bus.arb_proto_err), '0);
        chk("t5d.g", DW'(bus.src_grant), DW'(4'b0100));

        // reset between the beats of a pair
        go("t6a", 4'b0010, 4'b0010, 1'b0); chk("t6a.g", DW'(bus.src_grant), DW'(4'b0010));
        do_reset("t6rst");
        go("t6b", 4'b0011, 4'b0000, 1'b0); chk("t6b.g", DW'(bus.src_grant), DW'(4'b0001));

        // random traffic: sources hold until granted, pairs occasionally broken
        req = '0; atom = '0;
        for (int c = 0; c < 1500; c++) begin
            stall = ($urandom_range(0, 4) == 0);
            step("rnd");
            for (int i = 0; i < N; i++) begin
                if (i == m_g) begin
                    if (m_lock) begin
                        req[i]  = ($urandom_range(0, 15) != 0);
                        atom[i] = 1'($urandom % 2);
                    end else begin
                        req[i]  = 1'($urandom % 2);
                        atom[i] = ($urandom_range(0, 3) == 0);
                    end
                    d[i] = rnd_pkt();
                end else if (!req[i]) begin
                    req[i]  = ($urandom_range(0, 2) == 0);
                    atom[i] = ($urandom_range(0, 3) == 0);
                    d[i]    = rnd_pkt();
                end
            end
        end

        go("drain0", '0, '0, 1'b0);
        go("drain1", '0, '0, 1'b0);
        @(posedge rclk); #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
